// File: rtl/ahb_gpio_ctrl.sv
// AHB-Lite GPIO slave: byte-lane writable output register with set/clear aliases,
// synchronised inputs and per-bit rising-edge interrupt capture (W1C status).
module ahb_gpio_ctrl #(
  parameter int                   OUT_WIDTH   = 8,
  parameter int                   IN_WIDTH    = 10,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET   = {OUT_WIDTH{1'b1}},
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic                 HREADY,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [31:0]          HWDATA,
  output logic                 HREADYOUT,
  output logic [31:0]          HRDATA,
  output logic [OUT_WIDTH-1:0] GPIO_OUT,
  input  logic [IN_WIDTH-1:0]  GPIO_IN,
  output logic                 IRQ
);

  logic                 r_hsel, r_hwrite;
  logic [4:0]           r_haddr;
  logic [1:0]           r_htrans;
  logic [2:0]           r_hsize;
  logic [OUT_WIDTH-1:0] r_dout;
  logic [IN_WIDTH-1:0]  r_irq_en, r_irq_st, r_prev;
  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] r_sync;
  logic                 r_irq;

  logic                 w_wr, w_rd;
  logic [2:0]           w_off;
  logic [3:0]           w_lane;
  logic [31:0]          w_bmask;
  logic [OUT_WIDTH-1:0] w_om, w_ow;
  logic [IN_WIDTH-1:0]  w_im, w_iw, w_din, w_rise, w_w1c;
  logic                 w_unused;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hsel   <= 1'b0;
      r_haddr  <= '0;
      r_htrans <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= '0;
    end else if (HREADY) begin
      r_hsel   <= HSEL;
      r_haddr  <= HADDR[4:0];
      r_htrans <= HTRANS;
      r_hwrite <= HWRITE;
      r_hsize  <= HSIZE;
    end
  end

  assign w_off = r_haddr[4:2];
  assign w_wr  = r_hsel & r_htrans[1] & r_hwrite;
  assign w_rd  = r_hsel & r_htrans[1] & ~r_hwrite;

  // Oversized transfers (HSIZE>2) enable no lanes, so they write nothing.
  always_comb begin
    w_lane = '0;
    case (r_hsize)
      3'd0:    w_lane[r_haddr[1:0]] = 1'b1;
      3'd1:    w_lane = r_haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_lane = 4'b1111;
      default: w_lane = '0;
    endcase
  end

  assign w_bmask = {{8{w_lane[3]}}, {8{w_lane[2]}}, {8{w_lane[1]}}, {8{w_lane[0]}}};
  assign w_om    = w_bmask[OUT_WIDTH-1:0];
  assign w_ow    = HWDATA[OUT_WIDTH-1:0] & w_om;
  assign w_im    = w_bmask[IN_WIDTH-1:0];
  assign w_iw    = HWDATA[IN_WIDTH-1:0] & w_im;
  assign w_w1c   = (w_wr && w_off == 3'd5) ? w_iw : '0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dout   <= OUT_RESET;
      r_irq_en <= '0;
    end else if (w_wr) begin
      case (w_off)
        3'd0:    r_dout   <= (r_dout & ~w_om) | w_ow;
        3'd1:    r_dout   <= r_dout | w_ow;
        3'd2:    r_dout   <= r_dout & ~w_ow;
        3'd4:    r_irq_en <= (r_irq_en & ~w_im) | w_iw;
        default: ;
      endcase
    end
  end

  assign w_din  = r_sync[SYNC_STAGES-1];
  assign w_rise = w_din & ~r_prev;

  // A new edge beats a simultaneous W1C so no event is ever lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync   <= '0;
      r_prev   <= '0;
      r_irq_st <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], GPIO_IN};
      r_prev   <= w_din;
      r_irq_st <= (r_irq_st & ~w_w1c) | w_rise;
      r_irq    <= |(r_irq_st & r_irq_en);
    end
  end

  always_comb begin
    HRDATA = '0;
    if (w_rd) begin
      case (w_off)
        3'd0, 3'd1, 3'd2: HRDATA[OUT_WIDTH-1:0] = r_dout;
        3'd3:             HRDATA[IN_WIDTH-1:0]  = w_din;
        3'd4:             HRDATA[IN_WIDTH-1:0]  = r_irq_en;
        3'd5:             HRDATA[IN_WIDTH-1:0]  = r_irq_st;
        default:          HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign GPIO_OUT  = r_dout;
  assign IRQ       = r_irq;
  assign w_unused  = ^{HADDR[31:5], r_htrans[0], HWDATA, w_bmask};

endmodule

// File: tb/tb_ahb_gpio_ctrl.sv
// Scoreboard bench for ahb_gpio_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_ahb_gpio_ctrl;
  localparam int OW = 8;
  localparam int IW = 10;
  localparam int K_RD = 0, K_OUT = 1, K_IRQ = 2, K_HRD = 3;

  logic          HCLK = 1'b0;
  logic          HRESETn, HSEL, HREADY, HWRITE;
  logic [31:0]   HADDR, HWDATA, HRDATA;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HREADYOUT, IRQ;
  logic [OW-1:0] GPIO_OUT;
  logic [IW-1:0] GPIO_IN;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t rq[$];
  chk_t sq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic tb_rd_dp;

  ahb_gpio_ctrl #(.OUT_WIDTH(OW), .IN_WIDTH(IW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .GPIO_OUT(GPIO_OUT), .GPIO_IN(GPIO_IN), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  // Bench-side view of which cycles are read data phases.
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) tb_rd_dp <= 1'b0;
    else if (HREADY) tb_rd_dp <= HSEL & HTRANS[1] & ~HWRITE;

  function automatic void compare(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  always @(negedge HCLK) begin
    chk_t c;
    if (tb_rd_dp) begin
      if (rq.size() == 0) compare("unexpected_read", HRDATA, 32'hDEADBEEF);
      else begin
        c = rq.pop_front();
        compare(c.name, HRDATA, c.exp);
      end
    end
    while (sq.size() != 0) begin
      c = sq.pop_front();
      case (c.kind)
        K_OUT:   compare(c.name, 32'(GPIO_OUT), c.exp);
        K_IRQ:   compare(c.name, {31'd0, IRQ}, c.exp);
        default: compare(c.name, HRDATA, c.exp);
      endcase
    end
  end

  task automatic expect_st(int kind, logic [31:0] exp, string name);
    chk_t c;
    c.kind = kind; c.exp = exp; c.name = name;
    sq.push_back(c);
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = '0;
  endtask

  task automatic addr_ph(logic [31:0] a, logic w, logic [2:0] sz);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = w; HSIZE = sz;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d, logic [2:0] sz = 3'd2);
    addr_ph(a, 1'b1, sz);
    step();
    idle_bus();
    HWDATA = d;
    step();
  endtask

  task automatic rd(logic [31:0] a, logic [31:0] exp, string name);
    chk_t c;
    c.kind = K_RD; c.exp = exp; c.name = name;
    rq.push_back(c);
    addr_ph(a, 1'b0, 3'd2);
    step();
    idle_bus();
    step();
  endtask

  // Write immediately followed by a read of the same address.
  task automatic wr_rd(logic [31:0] a, logic [31:0] d, logic [31:0] exp, string name);
    chk_t c;
    c.kind = K_RD; c.exp = exp; c.name = name;
    addr_ph(a, 1'b1, 3'd2);
    step();
    HWDATA = d;
    rq.push_back(c);
    addr_ph(a, 1'b0, 3'd2);
    step();
    idle_bus();
    step();
  endtask

  initial begin
    HRESETn = 1'b0; HREADY = 1'b1; HWDATA = '0; GPIO_IN = 10'h2A5;
    idle_bus();
    step(3);
    expect_st(K_OUT, 32'hFF, "rst_gpio_out");
    expect_st(K_IRQ, 0, "rst_irq");
    HRESETn = 1'b1;
    step();
    expect_st(K_OUT, 32'hFF, "post_rst_gpio_out");
    expect_st(K_IRQ, 0, "post_rst_irq");
    expect_st(K_HRD, 0, "post_rst_hrdata");
    step(3);
    rd(32'h0C, 32'h2A5, "data_in");
    rd(32'h14, 32'h2A5, "status_after_sync_edges");
    expect_st(K_IRQ, 0, "irq_gated_by_en");
    wr(32'h14, 32'h3FF);
    rd(32'h14, 32'h0, "status_w1c_all");

    // Output register and set/clear aliases.
    wr(32'h00, 32'h5A);
    expect_st(K_OUT, 32'h5A, "out_write");
    wr(32'h04, 32'h81);
    expect_st(K_OUT, 32'hDB, "out_set");
    wr(32'h08, 32'h18);
    expect_st(K_OUT, 32'hC3, "out_clr");
    rd(32'h04, 32'hC3, "read_set_alias");
    wr_rd(32'h00, 32'h3C, 32'h3C, "b2b_wr_rd");

    // Byte lanes.
    wr(32'h00, 32'h00);
    wr(32'h01, 32'h0000FF00, 3'd0);
    expect_st(K_OUT, 32'h00, "byte_lane1_no_effect");
    wr(32'h00, 32'hFFFFFFA5, 3'd0);
    expect_st(K_OUT, 32'hA5, "byte_lane0");
    wr(32'h02, 32'hFFFFFFFF, 3'd1);
    expect_st(K_OUT, 32'hA5, "half_upper_no_effect");
    wr(32'h00, 32'h00, 3'd3);
    expect_st(K_OUT, 32'hA5, "hsize3_no_write");
    wr(32'h18, 32'hFFFFFFFF);
    rd(32'h18, 32'h0, "reserved_read");
    expect_st(K_OUT, 32'hA5, "reserved_write_ignored");

    // Interrupt on a rising edge of bit 0.
    wr(32'h10, 32'h001);
    rd(32'h10, 32'h001, "irq_en");
    GPIO_IN = 10'h2A4;
    step(4);
    rd(32'h14, 32'h0, "no_irq_on_fall");
    GPIO_IN = 10'h2A5;
    step(3);
    expect_st(K_IRQ, 0, "irq_not_yet");
    step();
    expect_st(K_IRQ, 1, "irq_asserted");
    rd(32'h14, 32'h001, "status_bit0");
    wr(32'h14, 32'h001);
    expect_st(K_IRQ, 1, "irq_reg_delay");
    step();
    expect_st(K_IRQ, 0, "irq_cleared");
    rd(32'h14, 32'h0, "status_cleared");

    // W1C data phase coincides with the cycle the new edge is seen.
    GPIO_IN = 10'h2A4;
    step(4);
    GPIO_IN = 10'h2A5;
    step();
    wr(32'h14, 32'h001);
    rd(32'h14, 32'h001, "set_beats_w1c");
    wr(32'h14, 32'h001);

    // Stalled address phase must not write.
    HREADY = 1'b0;
    addr_ph(32'h00, 1'b1, 3'd2);
    HWDATA = 32'h33;
    step();
    expect_st(K_OUT, 32'hA5, "stall_no_write_1");
    step();
    expect_st(K_OUT, 32'hA5, "stall_no_write_2");
    HREADY = 1'b1;
    step();
    idle_bus();
    step();
    expect_st(K_OUT, 32'h33, "write_after_stall");

    // Reset in the middle of a write data phase.
    addr_ph(32'h00, 1'b1, 3'd2);
    step();
    idle_bus();
    HWDATA = 32'h11;
    #2 HRESETn = 1'b0;
    expect_st(K_OUT, 32'hFF, "async_reset_out");
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    step(2);
    expect_st(K_OUT, 32'hFF, "no_write_after_reset");
    expect_st(K_IRQ, 0, "irq_after_reset");
    rd(32'h00, 32'hFF, "data_out_after_reset");
    rd(32'h10, 32'h0, "irq_en_after_reset");

    step(3);
    if (rq.size() != 0 || sq.size() != 0) begin
      n_chk++;
      $display("FAIL pending_checks: got %0d outstanding expected 0", rq.size() + sq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
